pcq_thold_seq_stg: RTL and testbench

Parametrised thold/scan-gate staging block with an ordered release sequencer. It carries NCH thold channels plus scan gate through DEPTH pipeline stages toward a unit's thold_0 level. A per-channel sequencer gate lets the pervasive controller release unit holds one channel at a time with a programmable spacing, which spreads power-up current steps, and re-assert all of them at once. It sits in pcq alongside the fixed-depth clock-staging tree and feeds core units whose channel count and distance differ.

---
 rtl/pcq_thold_seq_stg.sv | 79 +++++++
 tb/tb_pcq_thold_seq_stg.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pcq_thold_seq_stg.sv
// pcq_thold_seq_stg: staged thold/sg pipeline with ordered per-channel hold release
module pcq_thold_seq_stg #(
  parameter int NCH   = 8,
  parameter int DEPTH = 4,
  parameter int GAP   = 2
) (
  input  logic           nclk,
  input  logic           rst,
  input  logic           flush,
  input  logic           hold_req,
  input  logic [0:NCH-1] thold_in,
  input  logic           sg_in,
  output logic [0:NCH-1] thold_out,
  output logic           sg_out,
  output logic           seq_busy,
  output logic           seq_done
);
  localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int CW = GAP > 1 ? $clog2(GAP) : 1;
  typedef enum logic [1:0] {HOLD, REL, RUN} state_t;
  state_t         state;
  logic [IW-1:0]  idx;
  logic [CW-1:0]  cnt;
  logic [0:NCH-1] gate, gate_n, eff_n;
  logic [0:NCH-1] st [DEPTH];
  logic [DEPTH-1:0] sg_st;
  logic clr, last;
  assign clr  = state == REL && cnt == '0;
  assign last = clr && idx == IW'(NCH-1);
  always_comb begin
    gate_n = '0;
    for (int i = 0; i < NCH; i++)
      gate_n[i] = hold_req || state == HOLD || (gate[i] && !(clr && idx == IW'(i)));
  end
  assign eff_n = thold_in | gate_n;
  always_ff @(posedge nclk or posedge rst) begin
    if (rst) begin
      state    <= HOLD;
      idx      <= '0;
      cnt      <= '0;
      gate     <= '1;
      seq_done <= 1'b0;
    end else begin
      gate     <= gate_n;
      seq_done <= !hold_req && last;
      if (hold_req || state == HOLD) begin
        state <= hold_req ? HOLD : REL;
        idx   <= '0;
        cnt   <= '0;
      end else if (state == REL) begin
        if (last) begin
          state <= RUN;
          cnt   <= '0;
        end else if (cnt == CW'(GAP-1)) begin
          cnt <= '0;
          idx <= idx + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
  always_ff @(posedge nclk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) st[k] <= '1;
      sg_st <= '0;
    end else begin
      st[0]    <= eff_n;
      sg_st[0] <= sg_in;
      for (int k = 1; k < DEPTH; k++) begin
        st[k]    <= flush ? eff_n : st[k-1];
        sg_st[k] <= flush ? sg_in : sg_st[k-1];
      end
    end
  end
  assign thold_out = flush ? (thold_in | gate) : st[DEPTH-1];
  assign sg_out    = flush ? sg_in : sg_st[DEPTH-1];
  assign seq_busy  = state == REL;
endmodule

// File: tb/tb_pcq_thold_seq_stg.sv
// tb_pcq_thold_seq_stg: randomized scoreboard bench for two staging configurations
module tb_pcq_thold_seq_stg;
  logic nclk = 1'b0, rst = 1'b1, flush = 1'b0, hold_req = 1'b1, sg_in = 1'b0;
  logic [0:3] thold_in = '0;
  logic [0:3] th0;
  logic [0:0] th1, ti1;
  logic sg0, bz0, dn0, sg1, bz1, dn1;
  assign ti1[0] = thold_in[0];
  always #5 nclk = ~nclk;
  pcq_thold_seq_stg #(.NCH(4), .DEPTH(2), .GAP(3)) u0 (
    .nclk(nclk), .rst(rst), .flush(flush), .hold_req(hold_req), .thold_in(thold_in),
    .sg_in(sg_in), .thold_out(th0), .sg_out(sg0), .seq_busy(bz0), .seq_done(dn0));
  pcq_thold_seq_stg #(.NCH(1), .DEPTH(1), .GAP(1)) u1 (
    .nclk(nclk), .rst(rst), .flush(flush), .hold_req(hold_req), .thold_in(ti1),
    .sg_in(sg_in), .thold_out(th1), .sg_out(sg1), .seq_busy(bz1), .seq_done(dn1));
  typedef struct packed {
    logic [0:3] th0;
    logic sg0, bz0, dn0, th1, sg1, bz1, dn1;
  } exp_t;
  exp_t sb [$];
  int n_cmp = 0, n_err = 0;
  int n = 8;
  bit held [2];
  int e0 [2];
  bit mdn [2], mbz [2];
  logic [0:3] effh [2][0:4095];
  logic sgh [2][0:4095];
  function automatic int nc(int j); return j == 0 ? 4 : 1; endfunction
  function automatic int dp(int j); return j == 0 ? 2 : 1; endfunction
  function automatic int gp(int j); return j == 0 ? 3 : 1; endfunction
  function automatic logic [0:3] msk(int j);
    logic [0:3] m;
    m = j == 0 ? 4'b1111 : 4'b1000;
    return m;
  endfunction
  function automatic logic [0:3] gates(int j);
    logic [0:3] g;
    g = '0;
    for (int i = 0; i < nc(j); i++) g[i] = held[j] || (n < e0[j] + 1 + i * gp(j));
    return g;
  endfunction
  task automatic model_edge();
    n++;
    for (int j = 0; j < 2; j++) begin
      if (rst) begin
        held[j] = 1'b1;
        effh[j][n] = '1;
        sgh[j][n] = 1'b0;
        mdn[j] = 1'b0;
        mbz[j] = 1'b0;
      end else begin
        if (hold_req) held[j] = 1'b1;
        else if (held[j]) begin
          held[j] = 1'b0;
          e0[j] = n;
        end
        effh[j][n] = (thold_in & msk(j)) | gates(j);
        sgh[j][n] = sg_in;
        if (flush)
          for (int k = 1; k < dp(j); k++) begin
            effh[j][n-k] = effh[j][n];
            sgh[j][n-k] = sg_in;
          end
        mdn[j] = !held[j] && n == e0[j] + 1 + (nc(j) - 1) * gp(j);
        mbz[j] = !held[j] && n < e0[j] + 1 + (nc(j) - 1) * gp(j);
      end
    end
  endtask
  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < dp(j); k++) begin
        effh[j][n-k] = '1;
        sgh[j][n-k] = 1'b0;
      end
      held[j] = 1'b1;
      mdn[j] = 1'b0;
      mbz[j] = 1'b0;
    end
  endtask
  task automatic drive(input logic hr, input logic [0:3] ti, input logic sg, input logic fl, input logic rs);
    exp_t e;
    logic [0:3] t1;
    @(posedge nclk);
    model_edge();
    #1;
    if (rs && !rst) model_reset();
    rst = rs;
    hold_req = hr;
    thold_in = ti;
    sg_in = sg;
    flush = fl;
    e.th0 = flush ? (thold_in | gates(0)) : effh[0][n-dp(0)+1];
    e.sg0 = flush ? sg_in : sgh[0][n-dp(0)+1];
    t1 = flush ? ((thold_in & msk(1)) | gates(1)) : effh[1][n-dp(1)+1];
    e.th1 = t1[0];
    e.sg1 = flush ? sg_in : sgh[1][n-dp(1)+1];
    e.bz0 = mbz[0];
    e.dn0 = mdn[0];
    e.bz1 = mbz[1];
    e.dn1 = mdn[1];
    sb.push_back(e);
  endtask
  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, required %h", nm, $time, act, req);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge nclk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("thold_out0", th0, e.th0);
        chk("sg_out0", {3'b0, sg0}, {3'b0, e.sg0});
        chk("seq_busy0", {3'b0, bz0}, {3'b0, e.bz0});
        chk("seq_done0", {3'b0, dn0}, {3'b0, e.dn0});
        chk("thold_out1", {3'b0, th1[0]}, {3'b0, e.th1});
        chk("sg_out1", {3'b0, sg1}, {3'b0, e.sg1});
        chk("seq_busy1", {3'b0, bz1}, {3'b0, e.bz1});
        chk("seq_done1", {3'b0, dn1}, {3'b0, e.dn1});
      end
    end
  end
  initial begin
    logic hr, rs, fl;
    logic [0:3] ti;
    for (int j = 0; j < 2; j++) begin
      held[j] = 1'b1;
      e0[j] = 0;
      mdn[j] = 1'b0;
      mbz[j] = 1'b0;
      for (int i = 0; i < 4096; i++) begin
        effh[j][i] = '1;
        sgh[j][i] = 1'b0;
      end
    end
    repeat (3) drive(1, 4'b0000, 0, 0, 1);
    repeat (4) drive(1, 4'b0000, 0, 0, 0);
    repeat (16) drive(0, 4'b0000, 0, 0, 0);
    drive(0, 4'b0010, 1, 0, 0);
    repeat (3) drive(0, 4'b0000, 0, 0, 0);
    drive(0, 4'b0101, 0, 1, 0);
    drive(0, 4'b0101, 0, 1, 0);
    repeat (3) drive(0, 4'b0101, 0, 0, 0);
    drive(1, 4'b0000, 0, 0, 0);
    repeat (3) drive(1, 4'b0000, 0, 0, 0);
    repeat (5) drive(0, 4'b0000, 0, 0, 0);
    drive(1, 4'b0000, 0, 0, 0);
    repeat (3) drive(1, 4'b0000, 0, 0, 0);
    repeat (6) drive(0, 4'b0000, 0, 0, 0);
    drive(0, 4'b0000, 0, 0, 1);
    drive(0, 4'b0000, 0, 0, 0);
    repeat (16) drive(0, 4'b0000, 1, 0, 0);
    hr = 1'b0;
    rs = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 24) == 0) hr = !hr;
      rs = rs ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 199) == 0);
      ti = $urandom_range(0, 5) == 0 ? 4'($urandom) : 4'b0000;
      fl = !rs && $urandom_range(0, 14) == 0;
      drive(hr, ti, 1'($urandom), fl, rs);
    end
    @(negedge nclk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
